// File: rtl/ddr_port_arbiter_if.sv
// One DDR-style port bundle: combined read/write request, write data, read data and write response.
interface ddr_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8
);
    logic                  arw_valid;
    logic                  arw_ready;
    logic [ADDR_W-1:0]     arw_addr;
    logic                  arw_write;
    logic [LEN_W-1:0]      arw_len;

    logic                  w_valid;
    logic                  w_ready;
    logic                  w_last;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;

    logic                  r_valid;
    logic                  r_ready;
    logic                  r_last;
    logic [DATA_W-1:0]     r_data;

    logic                  b_valid;
    logic                  b_ready;

    modport master (
        output arw_valid, arw_addr, arw_write, arw_len,
        output w_valid, w_last, w_data, w_strb,
        output r_ready, b_ready,
        input  arw_ready, w_ready, r_valid, r_last, r_data, b_valid
    );

    modport slave (
        input  arw_valid, arw_addr, arw_write, arw_len,
        input  w_valid, w_last, w_data, w_strb,
        input  r_ready, b_ready,
        output arw_ready, w_ready, r_valid, r_last, r_data, b_valid
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Shares one DDR controller port between two masters: round-robin request grant with
// lock-on-stall, and in-order w/r/b routing driven by per-channel master-ID FIFOs.
module ddr_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    ddr_port_arbiter_if.slave      m0,
    ddr_port_arbiter_if.slave      m1,
    ddr_port_arbiter_if.master     s,
    output logic [$clog2(DEPTH):0] pending_reads,
    output logic [$clog2(DEPTH):0] pending_writes
);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned NQ     = 3;
    localparam int unsigned QR     = 0;
    localparam int unsigned QW     = 1;
    localparam int unsigned QB     = 2;

    typedef enum logic { GRANT_FREE = 1'b0, GRANT_LOCKED = 1'b1 } lock_e;

    lock_e             lock_q, lock_d;
    logic              lock_id_q, lock_id_d;
    logic              last_grant_q, last_grant_d;

    logic [DEPTH-1:0]  id_mem_q [NQ];
    logic [PTR_W-1:0]  rd_ptr_q [NQ];
    logic [PTR_W-1:0]  rd_ptr_d [NQ];
    logic [PTR_W-1:0]  wr_ptr_q [NQ];
    logic [PTR_W-1:0]  wr_ptr_d [NQ];
    logic [CNT_W-1:0]  cnt_q    [NQ];
    logic [CNT_W-1:0]  cnt_d    [NQ];

    logic [NQ-1:0]     full, empty, head;
    logic [NQ-1:0]     push, pop, push_ok, pop_ok;

    logic              elig0, elig1;
    logic              gnt_id, gnt_vld, arw_fire;
    logic [ADDR_W-1:0] arw_addr;
    logic [LEN_W-1:0]  arw_len;
    logic              arw_write;

    logic              w_own, w_act, w_vld, w_last;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic              r_own, r_act, r_rdy;
    logic              b_own, b_act, b_rdy;

    // Queue status is derived from registered counts only.
    always_comb begin
        for (int q = 0; q < NQ; q++) begin
            full[q]  = (cnt_q[q] == CNT_W'(DEPTH));
            empty[q] = (cnt_q[q] == '0);
            head[q]  = id_mem_q[q][rd_ptr_q[q]];
        end
    end

    assign elig0 = m0.arw_valid & (m0.arw_write ? ~(full[QW] | full[QB]) : ~full[QR]);
    assign elig1 = m1.arw_valid & (m1.arw_write ? ~(full[QW] | full[QB]) : ~full[QR]);

    // Grant selection: a stalled request keeps its master until it is accepted.
    always_comb begin
        gnt_id  = ~elig0;
        gnt_vld = elig0 | elig1;
        if (lock_q == GRANT_LOCKED) begin
            gnt_id  = lock_id_q;
            gnt_vld = lock_id_q ? elig1 : elig0;
        end else if (elig0 & elig1) begin
            gnt_id = ~last_grant_q;
        end
        gnt_vld = gnt_vld & ~reset;
    end

    assign arw_addr  = gnt_id ? m1.arw_addr  : m0.arw_addr;
    assign arw_len   = gnt_id ? m1.arw_len   : m0.arw_len;
    assign arw_write = gnt_id ? m1.arw_write : m0.arw_write;
    assign arw_fire  = gnt_vld & s.arw_ready;

    assign s.arw_valid  = gnt_vld;
    assign s.arw_addr   = arw_addr;
    assign s.arw_len    = arw_len;
    assign s.arw_write  = arw_write;
    assign m0.arw_ready = arw_fire & ~gnt_id;
    assign m1.arw_ready = arw_fire & gnt_id;

    // Write data follows the oldest accepted write.
    assign w_own  = head[QW];
    assign w_act  = ~empty[QW] & ~reset;
    assign w_vld  = w_act & (w_own ? m1.w_valid : m0.w_valid);
    assign w_last = w_own ? m1.w_last : m0.w_last;
    assign w_data = w_own ? m1.w_data : m0.w_data;
    assign w_strb = w_own ? m1.w_strb : m0.w_strb;

    assign s.w_valid   = w_vld;
    assign s.w_last    = w_last;
    assign s.w_data    = w_data;
    assign s.w_strb    = w_strb;
    assign m0.w_ready  = w_act & ~w_own & s.w_ready;
    assign m1.w_ready  = w_act & w_own & s.w_ready;

    // Read data returns in request order.
    assign r_own = head[QR];
    assign r_act = ~empty[QR] & ~reset;
    assign r_rdy = r_act & (r_own ? m1.r_ready : m0.r_ready);

    assign s.r_ready  = r_rdy;
    assign m0.r_valid = r_act & ~r_own & s.r_valid;
    assign m1.r_valid = r_act & r_own & s.r_valid;
    assign m0.r_last  = s.r_last;
    assign m1.r_last  = s.r_last;
    assign m0.r_data  = s.r_data;
    assign m1.r_data  = s.r_data;

    // Write responses return in request order.
    assign b_own = head[QB];
    assign b_act = ~empty[QB] & ~reset;
    assign b_rdy = b_act & (b_own ? m1.b_ready : m0.b_ready);

    assign s.b_ready  = b_rdy;
    assign m0.b_valid = b_act & ~b_own & s.b_valid;
    assign m1.b_valid = b_act & b_own & s.b_valid;

    always_comb begin
        push     = '0;
        pop      = '0;
        push[QR] = arw_fire & ~arw_write;
        push[QW] = arw_fire & arw_write;
        push[QB] = arw_fire & arw_write;
        pop[QR]  = s.r_valid & r_rdy & s.r_last;
        pop[QW]  = w_vld & s.w_ready & w_last;
        pop[QB]  = s.b_valid & b_rdy;
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
    end

    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        for (int q = 0; q < NQ; q++) begin
            rd_ptr_d[q] = rd_ptr_q[q];
            wr_ptr_d[q] = wr_ptr_q[q];
            cnt_d[q]    = cnt_q[q];
        end

        lock_d    = (gnt_vld & ~s.arw_ready) ? GRANT_LOCKED : GRANT_FREE;
        lock_id_d = gnt_id;
        if (arw_fire) begin
            last_grant_d = gnt_id;
        end
        for (int q = 0; q < NQ; q++) begin
            wr_ptr_d[q] = wr_ptr_q[q] + PTR_W'(push_ok[q]);
            rd_ptr_d[q] = rd_ptr_q[q] + PTR_W'(pop_ok[q]);
            cnt_d[q]    = cnt_q[q] + CNT_W'(push_ok[q]) - CNT_W'(pop_ok[q]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= GRANT_FREE;
            lock_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
            for (int q = 0; q < NQ; q++) begin
                id_mem_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                wr_ptr_q[q] <= '0;
                cnt_q[q]    <= '0;
            end
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            for (int q = 0; q < NQ; q++) begin
                if (push_ok[q]) begin
                    id_mem_q[q][wr_ptr_q[q]] <= gnt_id;
                end
                rd_ptr_q[q] <= rd_ptr_d[q];
                wr_ptr_q[q] <= wr_ptr_d[q];
                cnt_q[q]    <= cnt_d[q];
            end
        end
    end

    assign pending_reads  = cnt_q[QR];
    assign pending_writes = cnt_q[QB];
endmodule
